// File: rtl/msg_bram_writer.sv
// Packs 4-bit display codes (first code in [3:0]) into 16-bit words written to BRAM port A; write lands 1 cycle after the 4th nibble or msg_end.
// nib_ready drops during the write cycle and while full; `define MSG_CLEAR_EN pads the whole memory with PAD on start before filling.
module msg_bram_writer #(
  parameter int         ADDR_W = 4,
  parameter logic [3:0] PAD    = 4'hF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              nib_valid,
  input  logic [3:0]        nib_data,
  output logic              nib_ready,
  input  logic              msg_end,
  output logic              bram_ena,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_din,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

`ifdef MSG_CLEAR_EN
  typedef enum logic [2:0] {IDLE, FILL, WRITE, FULL, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FULL} state_t;
`endif

  state_t              state, state_n;
  logic [1:0]          slot, slot_n;
  logic [15:0]         shadow, shadow_n;
  logic                last, last_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [ADDR_W:0]     wc_q, wc_n;
  logic                full_q, full_n;
  logic                done_q, done_n;

  logic                accept;
  logic [2:0]          eff_cnt;
  logic [15:0]         ins, padded;
  logic                writing;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      slot   <= '0;
      shadow <= '0;
      last   <= 1'b0;
      addr_q <= '0;
      wc_q   <= '0;
      full_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      slot   <= slot_n;
      shadow <= shadow_n;
      last   <= last_n;
      addr_q <= addr_n;
      wc_q   <= wc_n;
      full_q <= full_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    shadow_n = shadow;
    last_n   = last;
    addr_n   = addr_q;
    wc_n     = wc_q;
    full_n   = full_q;
    done_n   = 1'b0;

    accept = (state == FILL) && nib_valid;
    ins = shadow;
    ins[{slot, 2'b00} +: 4] = nib_data;
    eff_cnt = {1'b0, slot} + {2'b00, accept};
    // msg_end may coincide with a nibble; pad only slots beyond everything accepted
    padded = accept ? ins : shadow;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= eff_cnt) padded[i*4 +: 4] = PAD;
    end

    if (start) begin
      // Highest priority in every state; a WRITE in progress still completes this cycle
`ifdef MSG_CLEAR_EN
      state_n = CLEAR;
`else
      state_n = FILL;
`endif
      slot_n   = '0;
      shadow_n = '0;
      last_n   = 1'b0;
      addr_n   = '0;
      wc_n     = '0;
      full_n   = 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (msg_end) begin
            if (eff_cnt == 3'd0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              shadow_n = padded;
              last_n   = 1'b1;
              state_n  = WRITE;
            end
          end else if (accept) begin
            shadow_n = ins;
            slot_n   = slot + 2'd1;
            if (slot == 2'd3) state_n = WRITE;
          end
        end
        WRITE: begin
          slot_n   = '0;
          shadow_n = '0;
          last_n   = 1'b0;
          wc_n     = wc_q + (ADDR_W+1)'(1);
          if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_n = FULL;
            full_n  = 1'b1;
          end else begin
            addr_n  = addr_q + ADDR_W'(1);
            state_n = FILL;
          end
        end
        FULL: begin
          if (msg_end) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
`ifdef MSG_CLEAR_EN
        CLEAR: begin
          if (addr_q == LAST_ADDR) begin
            addr_n  = '0;
            state_n = FILL;
          end else begin
            addr_n = addr_q + ADDR_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef MSG_CLEAR_EN
  assign writing  = (state == WRITE) || (state == CLEAR);
  assign bram_din = (state == WRITE) ? shadow : ((state == CLEAR) ? {4{PAD}} : 16'h0000);
`else
  assign writing  = (state == WRITE);
  assign bram_din = (state == WRITE) ? shadow : 16'h0000;
`endif

  assign nib_ready  = (state == FILL);
  assign bram_ena   = writing;
  assign bram_we    = writing;
  assign bram_addr  = addr_q;
  assign word_count = wc_q;
  assign full       = full_q;
  assign done       = done_q;

endmodule

// File: tb/tb_msg_bram_writer.sv
// Bench for msg_bram_writer: message-level reference model predicts BRAM writes and done pulses into queues; a negedge monitor pops and compares.
module tb_msg_bram_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        nib_valid = 1'b0;
  logic [3:0]  nib_data = 4'h0;
  logic        nib_ready;
  logic        msg_end = 1'b0;
  logic        bram_ena, bram_we;
  logic [3:0]  bram_addr;
  logic [15:0] bram_din;
  logic [4:0]  word_count;
  logic        full, done;

  msg_bram_writer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .nib_valid(nib_valid),
    .nib_data(nib_data), .nib_ready(nib_ready), .msg_end(msg_end),
    .bram_ena(bram_ena), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .word_count(word_count), .full(full), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_wr[$];
  int  exp_done[$];

  int errors = 0;
  int checks = 0;

  // Reference model: message-level bookkeeping
  int  m_buf[$];
  int  m_words;
  bit  m_active, m_wr, m_last, m_full;
  int  m_clr, m_clr_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return m_active && !m_wr && (m_clr == 0) && (m_words < 16);
  endfunction

  task automatic commit();
    int w = 0;
    while (m_buf.size() < 4) m_buf.push_back(15);
    for (int i = 0; i < 4; i++) w += m_buf[i] << (4 * i);
    exp_wr.push_back('{m_words, w});
    m_buf.delete();
    m_wr = 1;
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_words = 0; m_active = 0; m_wr = 0; m_last = 0; m_full = 0;
    m_clr = 0; m_clr_addr = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input logic [3:0] d, input bit me);
    bit rdy = model_ready();
    if (s) begin
      m_buf.delete();
      m_words = 0; m_active = 1; m_wr = 0; m_last = 0; m_full = 0;
`ifdef MSG_CLEAR_EN
      m_clr = 16; m_clr_addr = 0;
      exp_wr.push_back('{0, 16'hFFFF});
`else
      m_clr = 0;
`endif
    end else if (m_clr > 0) begin
      m_clr--;
      m_clr_addr++;
      if (m_clr > 0) exp_wr.push_back('{m_clr_addr, 16'hFFFF});
    end else if (m_wr) begin
      m_wr = 0;
      m_words++;
      if (m_last) begin
        m_active = 0; m_last = 0;
        exp_done.push_back(m_words);
      end else if (m_words == 16) begin
        m_full = 1;
      end
    end else if (m_active) begin
      if (rdy && v) m_buf.push_back(int'(d));
      if (me) begin
        if (m_buf.size() > 0) begin
          m_last = 1;
          commit();
        end else begin
          m_active = 0;
          exp_done.push_back(m_words);
        end
      end else if (m_buf.size() == 4) begin
        commit();
      end
    end
  endtask

  task automatic cyc(input bit s, input bit v, input logic [3:0] d, input bit me);
    @(posedge clk); #1;
    chk("nib_ready", nib_ready, model_ready());
    chk("full", full, m_full);
    start = s; nib_valid = v; nib_data = d; msg_end = me;
    model_step(s, v, d, me);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 0;
    start = 0; nib_valid = 0; msg_end = 0;
    model_reset();
    exp_wr.delete();
    exp_done.delete();
    #1;
    chk("rst_we", bram_we, 0);
    chk("rst_ena", bram_ena, 0);
    chk("rst_ready", nib_ready, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_din", bram_din, 0);
    @(negedge clk); #1;
    reset_n = 1;
  endtask

  // Monitor: compares every DUT write and done pulse against the model queues
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bram_we) begin
          if (exp_wr.size() == 0) begin
            chk("spurious_we", bram_we, 0);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", bram_addr, w.addr);
            chk("wr_data", bram_din, w.data);
            chk("wr_ena", bram_ena, 1);
          end
        end
        if (done) begin
          if (exp_done.size() == 0) chk("spurious_done", done, 0);
          else chk("done_wc", word_count, exp_done.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] seq2[6];
    seq2 = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h7, 4'h8};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_ready", nib_ready, 0);
    chk("init_we", bram_we, 0);
    chk("init_done", done, 0);
    reset_n = 1;

    // 4,3,2,1 -> 16'h1234 at addr 0
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'(4 - i), 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);

    // Partial final word padded
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, seq2[i], 0);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);

    // Fill all 16 words, then offer more
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 90; i++) cyc(0, 1, 4'h5, 0);
    cyc(0, 1, 4'h5, 1);
    repeat (3) cyc(0, 0, 0, 0);

    // Restart discards partial word; start+msg_end counts as start
    cyc(1, 0, 0, 0);
    cyc(0, 1, 4'h2, 0);
    cyc(0, 1, 4'h3, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'h9, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 0);

    // msg_end together with the final nibble of a word
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i + 1), 0);
    cyc(0, 1, 4'h6, 1);
    repeat (3) cyc(0, 0, 0, 0);

    // Reset during the write cycle
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'hE, 0);
    do_reset();
    repeat (3) cyc(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
    end
    cyc(0, 0, 0, 1);
    repeat (25) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0);

    @(negedge clk); #1;
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
